// File: rtl/dff_reg_pkg.sv
// Shared types and constants for the FIR delay-register slice.
// Feature macro: DFF_REG_CE_EN (adds a clock enable to dff_reg / dff_reg_stage).
package dff_reg_pkg;

    localparam int DFF_REG_DEFAULT_WIDTH = 16;

    typedef logic signed [15:0] fir_acc_t;

    localparam fir_acc_t FIR_ACC_ZERO = '0;

endpackage : dff_reg_pkg

// File: rtl/dff_reg_stage.sv
// One WIDTH-bit register stage with synchronous active-high reset.
// Feature macro: DFF_REG_CE_EN adds input ce; when low the stage holds its value.
module dff_reg_stage
    import dff_reg_pkg::*;
#(
    parameter int               WIDTH     = DFF_REG_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
`ifdef DFF_REG_CE_EN
    input  logic             ce,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next-state selection: load d, or hold when the enable is low.
    always_comb begin
        data_d = data_q;
`ifdef DFF_REG_CE_EN
        if (ce) begin
            data_d = d;
        end else begin
            data_d = data_q;
        end
`else
        data_d = d;
`endif
    end

    // State register; reset outranks the enable and the data path.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : dff_reg_stage

// File: rtl/dff_reg.sv
// Bit-exact delay line of STAGES back-to-back registers, used between FIR adder stages.
// Feature macro: DFF_REG_CE_EN adds input ce after reset (stall all stages when low).
module dff_reg
    import dff_reg_pkg::*;
#(
    parameter int               WIDTH     = DFF_REG_DEFAULT_WIDTH,
    parameter int               STAGES    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
`ifdef DFF_REG_CE_EN
    input  logic             ce,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];

    generate
        if (STAGES < 1 || WIDTH < 1) begin : g_param_check
            $fatal(1, "dff_reg: STAGES and WIDTH must both be at least 1");
        end

        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic [WIDTH-1:0] stage_d;

            if (k == 0) begin : g_head
                assign stage_d = d;
            end else begin : g_link
                assign stage_d = stage_q[k-1];
            end

            dff_reg_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
`ifdef DFF_REG_CE_EN
                .ce    (ce),
`endif
                .d     (stage_d),
                .q     (stage_q[k])
            );
        end
    endgenerate

    // q comes straight from the last stage's flops: no path from d or reset.
    assign q = stage_q[STAGES-1];

endmodule : dff_reg

// File: tb/tb_dff_reg.sv
// Directed, scoreboard-based bench for dff_reg: 1-stage and 3-stage instances plus a 13-tap FIR chain.
module tb_dff_reg;
    import dff_reg_pkg::*;

    localparam int N_TAPS = 13;
    localparam int FIR_COEF [N_TAPS] = '{2, 0, -9, -10, 20, 74, 102, 74, 20, -10, -9, 0, 2};
    localparam int FIR_EXP  [N_TAPS] = '{2, 0, -9, -10, 20, 74, 102, 74, 20, -10, -9, 0, 2};

    logic        clk = 1'b0;
    logic        r1  = 1'b1;
    logic [15:0] d1  = 16'h0000;
    logic [15:0] q1;
    logic        r3  = 1'b1;
    logic [15:0] d3  = 16'h0000;
    logic [15:0] q3;
`ifdef DFF_REG_CE_EN
    logic        ce  = 1'b1;
`endif

    logic        fir_rst = 1'b1;
    fir_acc_t    fir_din = FIR_ACC_ZERO;
    fir_acc_t    fir_dout;
    logic [15:0] fir_tap_q [1:N_TAPS];
    logic [15:0] fir_sum   [1:N_TAPS-1];

    logic [15:0] exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    dff_reg #(.WIDTH(16), .STAGES(1)) u_dut1 (
        .clk   (clk),
        .reset (r1),
`ifdef DFF_REG_CE_EN
        .ce    (ce),
`endif
        .d     (d1),
        .q     (q1)
    );

    dff_reg #(.WIDTH(16), .STAGES(3)) u_dut3 (
        .clk   (clk),
        .reset (r3),
`ifdef DFF_REG_CE_EN
        .ce    (ce),
`endif
        .d     (d3),
        .q     (q3)
    );

    // Transposed-form FIR: each tap register holds coef*x plus the next tap's partial sum.
    assign fir_tap_q[N_TAPS] = 16'h0000;
    for (genvar k = 1; k < N_TAPS; k++) begin : g_fir
        assign fir_sum[k] = 16'(fir_acc_t'(FIR_COEF[k] * int'(fir_din)) + fir_acc_t'(fir_tap_q[k+1]));
        dff_reg #(.WIDTH(16), .STAGES(1)) u_tap (
            .clk   (clk),
            .reset (fir_rst),
`ifdef DFF_REG_CE_EN
            .ce    (1'b1),
`endif
            .d     (fir_sum[k]),
            .q     (fir_tap_q[k])
        );
    end
    assign fir_dout = fir_acc_t'(FIR_COEF[0] * int'(fir_din)) + fir_acc_t'(fir_tap_q[1]);

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step1(input logic [15:0] dv, input logic rv, input logic [15:0] expv, input string tag);
        d1 = dv;
        r1 = rv;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        check(tag, q1, exp_q.pop_front());
    endtask

    task automatic step3(input logic [15:0] dv, input logic rv, input logic [15:0] expv, input string tag);
        d3 = dv;
        r3 = rv;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        check(tag, q3, exp_q.pop_front());
    endtask

    initial begin
        logic [15:0] v;

        // Single stage: reset, pass-through, sign/extremes, random, mid-stream reset.
        step1(16'h1234, 1'b1, 16'h0000, "rst_edge1");
        step1(16'h1234, 1'b1, 16'h0000, "rst_edge2");
        step1(16'd5,    1'b0, 16'd5,    "pass_5");
        step1(16'd204,  1'b0, 16'd204,  "pass_204");
        step1(16'hFF6E, 1'b0, 16'hFF6E, "pass_neg146");
        step1(16'h8000, 1'b0, 16'h8000, "min_neg");
        step1(16'h7FFF, 1'b0, 16'h7FFF, "max_pos");
        step1(16'hFFF6, 1'b0, 16'hFFF6, "neg10");
        for (int i = 0; i < 4; i++) begin
            v = 16'($urandom_range(0, 65535));
            step1(v, 1'b0, v, "rand");
        end
        step1(16'hAAAA, 1'b1, 16'h0000, "rst_mid1");
        step1(16'h5555, 1'b0, 16'h5555, "after_rst1");

        // Three stages: latency, then reset on the edge carrying 3.
        step3(16'd0,  1'b1, 16'd0,  "s3_rst");
        step3(16'd10, 1'b0, 16'd0,  "s3_fill0");
        step3(16'd11, 1'b0, 16'd0,  "s3_fill1");
        step3(16'd12, 1'b0, 16'd10, "s3_lat10");
        step3(16'd13, 1'b0, 16'd11, "s3_lat11");
        step3(16'd14, 1'b0, 16'd12, "s3_lat12");
        step3(16'd1,  1'b0, 16'd13, "s3_d1");
        step3(16'd2,  1'b0, 16'd14, "s3_d2");
        step3(16'd3,  1'b1, 16'd0,  "s3_rst_on3");
        step3(16'd4,  1'b0, 16'd0,  "s3_flush1");
        step3(16'd5,  1'b0, 16'd0,  "s3_flush2");
        step3(16'd6,  1'b0, 16'd4,  "s3_first4");
        step3(16'd7,  1'b0, 16'd5,  "s3_next5");

`ifdef DFF_REG_CE_EN
        ce = 1'b1;
        step1(16'd7, 1'b0, 16'd7, "ce_load7");
        ce = 1'b0;
        step1(16'd9, 1'b0, 16'd7, "ce_hold7");
        step1(16'd9, 1'b1, 16'd0, "ce_rst_wins");
        ce = 1'b1;
`endif

        // FIR impulse response through a chain of dff_reg instances.
        fir_rst = 1'b1;
        fir_din = FIR_ACC_ZERO;
        repeat (2) @(posedge clk);
        #1;
        fir_rst = 1'b0;
        for (int i = 0; i < N_TAPS; i++) begin
            fir_din = (i == 0) ? fir_acc_t'(16'sd1) : FIR_ACC_ZERO;
            exp_q.push_back(16'(FIR_EXP[i]));
            #2;
            check("fir_impulse", fir_dout, exp_q.pop_front());
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dff_reg
